// File: rtl/pr8_reader.sv
// PR8 paper-tape reader IOT interface: RSF/RRB/RFC decode, host byte fetch, delayed flag.
// Host bytes are accepted only while fetching, then held in a stage register until the delay ends.
module pr8_reader #(
  parameter logic [5:0]  DEV_CODE   = 6'o01,
  parameter int unsigned READ_DELAY = 16
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        iop_1,
  input  logic        iop_2,
  input  logic        iop_4,
  input  logic [11:0] io_bmb,
  input  logic        io_pwr_clr,
  input  logic [7:0]  host_data,
  input  logic        host_strobe,
  output logic        host_ready,
  output logic        io_skp_rq_l,
  output logic        io_int_rq_l,
  output logic [11:0] io_data_l,
  output logic        flag,
  output logic        busy
);

  localparam logic [15:0] DelayLoad = 16'(READ_DELAY - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDelay} state_e;

  state_e      state_q, state_d;
  logic        iop2_q, iop4_q;
  logic        flag_q, flag_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  stage_q, stage_d;
  logic [15:0] cnt_q, cnt_d;

  logic sel, rrb_hold, rrb_fall, rfc_rise, done;

  assign sel      = (io_bmb[11:9] == 3'o6) && (io_bmb[8:3] == DEV_CODE);
  assign rrb_hold = iop_2 & sel;
  assign rrb_fall = ~iop_2 & iop2_q & sel;
  assign rfc_rise = iop_4 & ~iop4_q & sel;

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    rbuf_d  = rbuf_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rfc_rise) state_d = StFetch;
      end
      StFetch: begin
        if (host_strobe) begin
          stage_d = host_data;
          cnt_d   = DelayLoad;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rrb_hold) begin
          // Completion waits out an active RRB so the bus data never changes mid-pulse.
          rbuf_d  = stage_q;
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      flag_d = 1'b1;
    end else if (rfc_rise || rrb_fall) begin
      flag_d = 1'b0;
    end

    if (io_pwr_clr) begin
      state_d = StIdle;
      flag_d  = 1'b0;
      rbuf_d  = 8'd0;
      stage_d = 8'd0;
      cnt_d   = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      flag_q  <= 1'b0;
      rbuf_q  <= 8'd0;
      stage_q <= 8'd0;
      cnt_q   <= 16'd0;
      iop2_q  <= 1'b0;
      iop4_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      rbuf_q  <= rbuf_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      iop2_q  <= io_pwr_clr ? 1'b0 : iop_2;
      iop4_q  <= io_pwr_clr ? 1'b0 : iop_4;
    end
  end

  assign host_ready  = (state_q == StFetch);
  assign busy        = (state_q != StIdle);
  assign flag        = flag_q;
  assign io_int_rq_l = ~flag_q;
  assign io_skp_rq_l = ~(iop_1 & sel & flag_q);
  assign io_data_l   = rrb_hold ? ~{4'b0000, rbuf_q} : 12'o7777;

endmodule
